// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC3 decode stage.
// Optional macro LC3_DECODE_ILLEGAL_EN (see lc3_decode.sv) does not affect this file.
package lc3_pkg;

    localparam int INSTR_W_DEF = 16;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCS1_NONE = 2'b00;
    localparam logic [1:0] PCS1_OFF9 = 2'b01;
    localparam logic [1:0] PCS1_OFF6 = 2'b10;
    localparam logic [1:0] PCS1_ZERO = 2'b11;

    localparam logic PCS2_BASER = 1'b0;
    localparam logic PCS2_NPC   = 1'b1;

    localparam logic OP2_IMM5 = 1'b0;
    localparam logic OP2_REG  = 1'b1;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_control_t;

    typedef enum logic [1:0] {
        W_ALU = 2'b00,
        W_PC  = 2'b01,
        W_MEM = 2'b10
    } w_control_t;

    typedef struct packed {
        e_control_t e;
        w_control_t w;
        logic       mem;
    } ctl_t;

endpackage

// File: rtl/lc3_decode_if.sv
// Fetch-to-decode and decode-to-execute bus for the LC3 decode stage.
// illegal_op exists only when LC3_DECODE_ILLEGAL_EN is defined.
interface lc3_decode_if
    import lc3_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
);
    logic [INSTR_W-1:0] dout;
    logic [INSTR_W-1:0] npc_in;
    logic               instr_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] npc_out;
    logic [5:0]         e_control;
    logic [1:0]         w_control;
    logic               mem_control;
    logic               dec_valid;
    logic               ex_ready;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic               illegal_op;
`endif

    modport master (
        output dout, npc_in, instr_valid, ex_ready,
        input  dec_ready, ir, npc_out, e_control, w_control, mem_control, dec_valid
`ifdef LC3_DECODE_ILLEGAL_EN
        , input illegal_op
`endif
    );

    modport slave (
        input  dout, npc_in, instr_valid, ex_ready,
        output dec_ready, ir, npc_out, e_control, w_control, mem_control, dec_valid
`ifdef LC3_DECODE_ILLEGAL_EN
        , output illegal_op
`endif
    );

endinterface

// File: rtl/lc3_decode_logic.sv
// Combinational opcode decoder: opcode + imm flag -> control bundle and illegal flag.
// Illegal opcodes leave every control at zero.
module lc3_decode_logic
    import lc3_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_imm_flag,
    output ctl_t       o_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_ctl.e   = '0;
        o_ctl.w   = W_ALU;
        o_ctl.mem = 1'b0;
        o_illegal = 1'b0;
        case (opcode_e'(i_opcode))
            OP_ADD: begin
                o_ctl.e.alu_control = ALU_ADD;
                o_ctl.e.op2select   = ~i_imm_flag;
            end
            OP_AND: begin
                o_ctl.e.alu_control = ALU_AND;
                o_ctl.e.op2select   = ~i_imm_flag;
            end
            OP_NOT: begin
                o_ctl.e.alu_control = ALU_NOT;
                o_ctl.e.op2select   = OP2_REG;
            end
            OP_BR, OP_ST: begin
                o_ctl.e.pcselect1 = PCS1_OFF9;
                o_ctl.e.pcselect2 = PCS2_NPC;
            end
            OP_JMP: begin
                o_ctl.e.pcselect1 = PCS1_ZERO;
                o_ctl.e.pcselect2 = PCS2_BASER;
            end
            OP_LD: begin
                o_ctl.e.pcselect1 = PCS1_OFF9;
                o_ctl.e.pcselect2 = PCS2_NPC;
                o_ctl.w           = W_MEM;
            end
            OP_LDI: begin
                o_ctl.e.pcselect1 = PCS1_OFF9;
                o_ctl.e.pcselect2 = PCS2_NPC;
                o_ctl.w           = W_MEM;
                o_ctl.mem         = 1'b1;
            end
            OP_LDR: begin
                o_ctl.e.pcselect1 = PCS1_OFF6;
                o_ctl.w           = W_MEM;
            end
            OP_LEA: begin
                o_ctl.e.pcselect1 = PCS1_OFF9;
                o_ctl.e.pcselect2 = PCS2_NPC;
                o_ctl.w           = W_PC;
            end
            OP_STI: begin
                o_ctl.e.pcselect1 = PCS1_OFF9;
                o_ctl.e.pcselect2 = PCS2_NPC;
                o_ctl.mem         = 1'b1;
            end
            OP_STR: begin
                o_ctl.e.pcselect1 = PCS1_OFF6;
            end
            OP_JSR, OP_RTI, OP_RES, OP_TRAP: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: input-side decode, output register plus one-entry skid buffer.
// Define LC3_DECODE_ILLEGAL_EN to present illegal opcodes with illegal_op instead of dropping them.
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         enable_decode,
    input  logic         br_taken,
    lc3_decode_if.slave  bus
);

    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_ir;
    logic [INSTR_W-1:0] r_out_npc;
    ctl_t               r_out_ctl;
    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_ir;
    logic [INSTR_W-1:0] r_skid_npc;
    ctl_t               r_skid_ctl;

    ctl_t w_ctl;
    logic w_illegal;
    logic w_keep;
    logic w_ready;
    logic w_accept;
    logic w_handoff;
    logic w_flow;
    logic w_out_free;
    logic w_ld_out_skid;
    logic w_ld_out_in;
    logic w_ld_skid;

    lc3_decode_logic u_logic (
        .i_opcode   (bus.dout[INSTR_W-1 -: 4]),
        .i_imm_flag (bus.dout[5]),
        .o_ctl      (w_ctl),
        .o_illegal  (w_illegal)
    );

`ifdef LC3_DECODE_ILLEGAL_EN
    assign w_keep = 1'b1;
`else
    assign w_keep = ~w_illegal;
`endif

    // Ready depends only on state so fetch never sees a path from ex_ready.
    assign w_ready       = enable_decode && !r_skid_valid && !reset;
    assign w_accept      = bus.instr_valid && w_ready;
    assign w_handoff     = r_out_valid && bus.ex_ready && enable_decode;
    assign w_flow        = !reset && !br_taken && enable_decode;
    assign w_out_free    = !r_out_valid || w_handoff;
    assign w_ld_out_skid = w_flow && w_out_free && r_skid_valid;
    assign w_ld_out_in   = w_flow && w_out_free && !r_skid_valid && w_accept && w_keep;
    assign w_ld_skid     = w_flow && !w_out_free && w_accept && w_keep;

    always_ff @(posedge clock) begin
        if (reset || br_taken) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (enable_decode) begin
            if (w_out_free)
                r_out_valid <= w_ld_out_skid || w_ld_out_in;
            if (w_ld_out_skid)
                r_skid_valid <= 1'b0;
            else if (w_ld_skid)
                r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_ir   <= '0;
            r_out_npc  <= '0;
            r_out_ctl  <= '0;
            r_skid_ir  <= '0;
            r_skid_npc <= '0;
            r_skid_ctl <= '0;
        end else begin
            if (w_ld_out_skid) begin
                r_out_ir  <= r_skid_ir;
                r_out_npc <= r_skid_npc;
                r_out_ctl <= r_skid_ctl;
            end else if (w_ld_out_in) begin
                r_out_ir  <= bus.dout;
                r_out_npc <= bus.npc_in;
                r_out_ctl <= w_ctl;
            end
            if (w_ld_skid) begin
                r_skid_ir  <= bus.dout;
                r_skid_npc <= bus.npc_in;
                r_skid_ctl <= w_ctl;
            end
        end
    end

`ifdef LC3_DECODE_ILLEGAL_EN
    logic r_out_ill;
    logic r_skid_ill;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_ill  <= 1'b0;
            r_skid_ill <= 1'b0;
        end else begin
            if (w_ld_out_skid)
                r_out_ill <= r_skid_ill;
            else if (w_ld_out_in)
                r_out_ill <= w_illegal;
            if (w_ld_skid)
                r_skid_ill <= w_illegal;
        end
    end

    assign bus.illegal_op = r_out_ill;
`endif

    assign bus.dec_ready   = w_ready;
    assign bus.dec_valid   = r_out_valid;
    assign bus.ir          = r_out_ir;
    assign bus.npc_out     = r_out_npc;
    assign bus.e_control   = r_out_ctl.e;
    assign bus.w_control   = r_out_ctl.w;
    assign bus.mem_control = r_out_ctl.mem;

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode: opcode table, stall/flush/reset sequences, random traffic vs queue model.
// Builds with or without LC3_DECODE_ILLEGAL_EN.
module tb_lc3_decode;

    localparam int W = 16;
`ifdef LC3_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic enable_decode;
    logic br_taken;

    lc3_decode_if #(.INSTR_W(W)) bus ();

    lc3_decode #(.INSTR_W(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .br_taken      (br_taken),
        .bus           (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        logic       ill;
    } tb_ctl_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        tb_ctl_t     c;
    } word_t;

    typedef struct packed {
        logic [15:0] ins;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    word_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table transcribed directly: alu, pcsel1, pcsel2, op2sel, w, mem, illegal.
    function automatic tb_ctl_t ref_dec(input logic [15:0] ins);
        case (ins[15:12])
            4'b0001: return {2'b00, 2'b00, 1'b0, ~ins[5], 2'b00, 1'b0, 1'b0};
            4'b0101: return {2'b01, 2'b00, 1'b0, ~ins[5], 2'b00, 1'b0, 1'b0};
            4'b1001: return {2'b10, 2'b00, 1'b0, 1'b1,    2'b00, 1'b0, 1'b0};
            4'b0000: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b00, 1'b0, 1'b0};
            4'b1100: return {2'b00, 2'b11, 1'b0, 1'b0,    2'b00, 1'b0, 1'b0};
            4'b0010: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b10, 1'b0, 1'b0};
            4'b1010: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b10, 1'b1, 1'b0};
            4'b0110: return {2'b00, 2'b10, 1'b0, 1'b0,    2'b10, 1'b0, 1'b0};
            4'b1110: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b01, 1'b0, 1'b0};
            4'b0011: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b00, 1'b0, 1'b0};
            4'b1011: return {2'b00, 2'b01, 1'b1, 1'b0,    2'b00, 1'b1, 1'b0};
            4'b0111: return {2'b00, 2'b10, 1'b0, 1'b0,    2'b00, 1'b0, 1'b0};
            default: return {6'b000000, 2'b00, 1'b0, 1'b1};
        endcase
    endfunction

    // Check outputs against the model mid-cycle, then advance the model across the next edge.
    task automatic step();
        bit    exp_rdy;
        bit    acc;
        bit    ho;
        word_t wd;
        @(negedge clock);
        exp_rdy = enable_decode && !reset && (q.size() < 2);
        chk("dec_ready", 32'(bus.dec_ready), 32'(exp_rdy));
        chk("dec_valid", 32'(bus.dec_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("ir",          32'(bus.ir),          32'(q[0].ir));
            chk("npc_out",     32'(bus.npc_out),     32'(q[0].npc));
            chk("e_control",   32'(bus.e_control),   32'(q[0].c.e));
            chk("w_control",   32'(bus.w_control),   32'(q[0].c.w));
            chk("mem_control", 32'(bus.mem_control), 32'(q[0].c.m));
`ifdef LC3_DECODE_ILLEGAL_EN
            chk("illegal_op",  32'(bus.illegal_op),  32'(q[0].c.ill));
`endif
        end
        acc = bus.instr_valid && exp_rdy;
        ho  = (q.size() > 0) && bus.ex_ready && enable_decode;
        if (reset || br_taken) begin
            q.delete();
        end else if (enable_decode) begin
            if (ho) void'(q.pop_front());
            if (acc) begin
                wd.ir  = bus.dout;
                wd.npc = bus.npc_in;
                wd.c   = ref_dec(bus.dout);
                if (ILL_EN || !wd.c.ill) q.push_back(wd);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [15:0] ins, input logic [15:0] npc);
        bus.dout        = ins;
        bus.npc_in      = npc;
        bus.instr_valid = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dec_valid"}, 32'(bus.dec_valid),   32'd0);
        chk({tag, "_ir"},        32'(bus.ir),          32'd0);
        chk({tag, "_npc"},       32'(bus.npc_out),     32'd0);
        chk({tag, "_e"},         32'(bus.e_control),   32'd0);
        chk({tag, "_w"},         32'(bus.w_control),   32'd0);
        chk({tag, "_mem"},       32'(bus.mem_control), 32'd0);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk({tag, "_ill"},       32'(bus.illegal_op),  32'd0);
`endif
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{16'h1261, 6'b000000, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{16'hA005, 6'b000110, 2'b10, 1'b1, 1'b0};
        tbl[2]  = '{16'h7042, 6'b001000, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{16'h1042, 6'b000001, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{16'h5042, 6'b010001, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{16'h5060, 6'b010000, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{16'h907F, 6'b100001, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{16'h0E05, 6'b000110, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{16'hC1C0, 6'b001100, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{16'h2005, 6'b000110, 2'b10, 1'b0, 1'b0};
        tbl[10] = '{16'h6042, 6'b001000, 2'b10, 1'b0, 1'b0};
        tbl[11] = '{16'hE005, 6'b000110, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{16'h3005, 6'b000110, 2'b00, 1'b0, 1'b0};
        tbl[13] = '{16'hB005, 6'b000110, 2'b00, 1'b1, 1'b0};
        tbl[14] = '{16'hF025, 6'b000000, 2'b00, 1'b0, 1'b1};
        tbl[15] = '{16'h4801, 6'b000000, 2'b00, 1'b0, 1'b1};
        tbl[16] = '{16'hD000, 6'b000000, 2'b00, 1'b0, 1'b1};

        reset           = 1'b1;
        enable_decode   = 1'b1;
        br_taken        = 1'b0;
        bus.dout        = '0;
        bus.npc_in      = '0;
        bus.instr_valid = 1'b0;
        bus.ex_ready    = 1'b1;
        step();
        step();
        chk_zero("reset");
        chk("reset_ready", 32'(bus.dec_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(bus.dec_ready), 32'd1);

        // Opcode table, one word per cycle at full throughput.
        for (int i = 0; i < 17; i++) begin
            offer(tbl[i].ins, 16'h3001 + 16'(i));
            step();
            if (ILL_EN || !tbl[i].ill) begin
                chk("tbl_valid", 32'(bus.dec_valid),   32'd1);
                chk("tbl_npc",   32'(bus.npc_out),     32'(16'h3001 + 16'(i)));
                chk("tbl_e",     32'(bus.e_control),   32'(tbl[i].e));
                chk("tbl_w",     32'(bus.w_control),   32'(tbl[i].w));
                chk("tbl_mem",   32'(bus.mem_control), 32'(tbl[i].m));
`ifdef LC3_DECODE_ILLEGAL_EN
                chk("tbl_ill",   32'(bus.illegal_op),  32'(tbl[i].ill));
`endif
            end else begin
                chk("tbl_drop_valid", 32'(bus.dec_valid), 32'd0);
            end
        end
        bus.instr_valid = 1'b0;
        step();

        // Stall with three words offered; the third waits until the skid drains.
        bus.ex_ready = 1'b0;
        offer(16'h1111, 16'h0101);
        step();
        offer(16'h2222, 16'h0202);
        step();
        chk("stall_ready", 32'(bus.dec_ready), 32'd0);
        chk("stall_ir1",   32'(bus.ir),        32'h1111);
        offer(16'h5333, 16'h0303);
        step();
        chk("stall_hold_ir", 32'(bus.ir), 32'h1111);
        bus.ex_ready = 1'b1;
        step();
        chk("drain_ir2",    32'(bus.ir),        32'h2222);
        chk("drain_ready",  32'(bus.dec_ready), 32'd1);
        step();
        chk("drain_ir3",    32'(bus.ir),        32'h5333);
        chk("drain_npc3",   32'(bus.npc_out),   32'h0303);
        bus.instr_valid = 1'b0;
        step();
        chk("drain_empty",  32'(bus.dec_valid), 32'd0);

        // Flush with both registers full; nothing stored may reappear.
        bus.ex_ready = 1'b0;
        offer(16'h1aaa, 16'h0a0a);
        step();
        offer(16'h1bbb, 16'h0b0b);
        step();
        bus.instr_valid = 1'b0;
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        chk("flush_valid", 32'(bus.dec_valid), 32'd0);
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_stays_empty", 32'(bus.dec_valid), 32'd0);
        end

        // Reset while both registers are full.
        bus.ex_ready = 1'b0;
        offer(16'h1ccc, 16'h0c0c);
        step();
        offer(16'h1ddd, 16'h0d0d);
        step();
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        step();
        chk_zero("midreset");
        chk("midreset_ready", 32'(bus.dec_ready), 32'd0);
        reset = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        chk("reset_release_ready", 32'(bus.dec_ready), 32'd1);

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(63) == 0);
            br_taken        = ($urandom_range(15) == 0);
            enable_decode   = ($urandom_range(7) != 0);
            bus.instr_valid = ($urandom_range(3) != 0);
            bus.ex_ready    = ($urandom_range(1) == 1);
            bus.dout        = 16'($urandom);
            bus.npc_in      = 16'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
